// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Two requesters share a single 4-bit add/subtract datapath. The requester
// to serve is chosen in IDLE; ties go to the round-robin pointer. The operands
// are latched on the grant edge and evaluated in EXEC. The result is then held
// in DONE until the consumer takes it with the RVALID/RREADY handshake.
//
// Ports
//   CLOCK_50          : clock, rising edge
//   RESETN            : asynchronous active-low reset
//   REQ0/REQ1         : requester has an operation pending (held until granted)
//   A0,B0,OP0/A1,B1,OP1 : operands and op select (0 = A+B, 1 = A-B)
//   GNT0/GNT1         : one-cycle acceptance strobe (operands sampled this cycle)
//   RVALID/RREADY     : result handshake
//   RESULT,COUT,OVF   : 4-bit result, raw carry out of bit 3, signed overflow
//   RID               : requester that owns RESULT
module addsub_arbiter (
   input  logic       CLOCK_50,
   input  logic       RESETN,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic [3:0] A0,
   input  logic [3:0] B0,
   input  logic [3:0] A1,
   input  logic [3:0] B1,
   input  logic       OP0,
   input  logic       OP1,
   output logic       GNT0,
   output logic       GNT1,
   output logic       RVALID,
   input  logic       RREADY,
   output logic [3:0] RESULT,
   output logic       RID,
   output logic       COUT,
   output logic       OVF
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       pri_q, pri_d;
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic       op_q, op_d;
   logic       id_q, id_d;
   logic [3:0] result_q, result_d;
   logic       cout_q, cout_d;
   logic       ovf_q, ovf_d;
   logic       rid_q, rid_d;

   logic       grant_any;
   logic       grant_sel;
   logic [3:0] b_x;
   logic [4:0] sum;
   logic       carry_in3;

   // Arbitration: on a tie the pointer decides. Otherwise the only active
   // requester wins. grant_sel is a don't-care when nobody is requesting.
   assign grant_sel = (REQ0 && REQ1) ? pri_q : REQ1;
   assign grant_any = (state_q == IDLE) && (REQ0 || REQ1);

   // Shared datapath: A + (B ^ {4{OP}}) + OP. The carry into bit 3 is
   // recovered from the sum bit, so no separate 3-bit adder is needed.
   assign b_x       = b_q ^ {4{op_q}};
   assign sum       = {1'b0, a_q} + {1'b0, b_x} + {4'b0000, op_q};
   assign carry_in3 = sum[3] ^ a_q[3] ^ b_x[3];

   // State and data registers
   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state_q  <= IDLE;
         pri_q    <= 1'b0;
         a_q      <= 4'd0;
         b_q      <= 4'd0;
         op_q     <= 1'b0;
         id_q     <= 1'b0;
         result_q <= 4'd0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         rid_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pri_q    <= pri_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         id_q     <= id_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         rid_q    <= rid_d;
      end
   end

   // Next-state logic. Result registers only change when leaving EXEC, so they
   // keep their last values across the handshake and the following IDLE.
   always_comb begin
      state_d  = state_q;
      pri_d    = pri_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      id_d     = id_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      rid_d    = rid_q;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               a_d     = grant_sel ? A1  : A0;
               b_d     = grant_sel ? B1  : B0;
               op_d    = grant_sel ? OP1 : OP0;
               id_d    = grant_sel;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = sum[3:0];
            cout_d   = sum[4];
            ovf_d    = carry_in3 ^ sum[4];
            rid_d    = id_q;
            state_d  = DONE;
         end
         DONE: begin
            if (RREADY) begin
               // The requester just served loses the next tie.
               pri_d   = ~rid_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs. The grant is a combinational strobe during the IDLE cycle. It is
   // gated by RESETN so that it also reads 0 while reset is held.
   always_comb begin
      GNT0   = RESETN && grant_any && !grant_sel;
      GNT1   = RESETN && grant_any &&  grant_sel;
      RVALID = (state_q == DONE);
      RESULT = result_q;
      RID    = rid_q;
      COUT   = cout_q;
      OVF    = ovf_q;
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic       op0, op1;
   logic       gnt0, gnt1;
   logic       rvalid, rready;
   logic [3:0] result;
   logic       rid, cout, ovf;

   typedef struct {
      logic       rid;
      logic [3:0] res;
      logic       cout;
      logic       ovf;
   } exp_t;

   exp_t exp_q[$];
   int   gnt_cyc_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   addsub_arbiter dut (
      .CLOCK_50 (clk),
      .RESETN   (rst_n),
      .REQ0     (req0),
      .REQ1     (req1),
      .A0       (a0),
      .B0       (b0),
      .A1       (a1),
      .B1       (b1),
      .OP0      (op0),
      .OP1      (op1),
      .GNT0     (gnt0),
      .GNT1     (gnt1),
      .RVALID   (rvalid),
      .RREADY   (rready),
      .RESULT   (result),
      .RID      (rid),
      .COUT     (cout),
      .OVF      (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "timeout");
   end

   task automatic push_exp(input logic r, input logic [3:0] res, input logic c, input logic o);
      exp_t e;
      e.rid = r; e.res = res; e.cout = c; e.ovf = o;
      exp_q.push_back(e);
   endtask

   // The caller must be at a negedge with the inputs already driven. The
   // current cycle is checked first, then up to max_cyc-1 following cycles.
   task automatic wait_gnt(input int idx, input int max_cyc, input bit track, output int at_cyc);
      bit got;
      got    = 1'b0;
      at_cyc = -1;
      for (int i = 0; i < max_cyc && !got; i++) begin
         #1;
         if (gnt0 || gnt1) begin
            got    = 1'b1;
            at_cyc = cyc;
            n_tests++;
            if ((idx == 0 && !(gnt0 && !gnt1)) || (idx == 1 && !(gnt1 && !gnt0))) begin
               n_fail++;
               $display("FAIL grant_order: GNT0=%0b GNT1=%0b at cycle %0d, required GNT%0d only", gnt0, gnt1, cyc, idx);
            end else begin
               $display("[TB] grant GNT%0d at cycle %0d", idx, cyc);
            end
            if (track) gnt_cyc_q.push_back(cyc);
         end else if (i + 1 < max_cyc) begin
            @(negedge clk);
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL grant_timeout: no grant within %0d cycles, required GNT%0d", max_cyc, idx);
      end
   endtask

   task automatic drain(input int max_cyc);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < max_cyc) begin
         @(negedge clk);
         i++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
      end
   endtask

   // Monitor: pops and compares on every result handshake, checks latency on
   // each RVALID rise, and checks the grant rules on every cycle.
   initial begin
      logic  prev_rvalid;
      exp_t  e;
      int    g;
      prev_rvalid = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (gnt0 || gnt1) begin
            n_tests++;
            if ((gnt0 && gnt1) || (gnt0 && !req0) || (gnt1 && !req1) || rvalid) begin
               n_fail++;
               $display("FAIL grant_rules: GNT0=%0b GNT1=%0b REQ0=%0b REQ1=%0b RVALID=%0b, required single grant with matching REQ outside DONE",
                        gnt0, gnt1, req0, req1, rvalid);
            end
         end
         if (rvalid && !prev_rvalid) begin
            n_tests++;
            if (gnt_cyc_q.size() == 0) begin
               n_fail++;
               $display("FAIL latency: RVALID rose at cycle %0d with no tracked grant, required none", cyc);
            end else begin
               g = gnt_cyc_q.pop_front();
               if (cyc != g + 2) begin
                  n_fail++;
                  $display("FAIL latency: RVALID at cycle %0d, required cycle %0d", cyc, g + 2);
               end
            end
         end
         if (rvalid && rready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL result_unexpected: RESULT=%b RID=%0b, required no result", result, rid);
            end else begin
               e = exp_q.pop_front();
               if (result !== e.res || rid !== e.rid || cout !== e.cout || ovf !== e.ovf) begin
                  n_fail++;
                  $display("FAIL result: RESULT=%b COUT=%0b OVF=%0b RID=%0b, required RESULT=%b COUT=%0b OVF=%0b RID=%0b",
                           result, cout, ovf, rid, e.res, e.cout, e.ovf, e.rid);
               end else begin
                  $display("[TB] result RESULT=%b COUT=%0b OVF=%0b RID=%0b ok", result, cout, ovf, rid);
               end
            end
         end
         prev_rvalid = rvalid;
      end
   end

   initial begin
      int         c, prev_c;
      logic [3:0] hold_res;
      bit         seen;

      rst_n  = 1'b0;
      req0   = 1'b1;  // a request under reset must not be granted
      req1   = 1'b0;
      a0 = 4'b0111; b0 = 4'b0001; op0 = 1'b0;
      a1 = 4'd0;    b1 = 4'd0;    op1 = 1'b0;
      rready = 1'b1;

      // Reset state
      @(negedge clk); #1;
      n_tests++;
      if (rvalid !== 1'b0 || result !== 4'd0 || rid !== 1'b0 || cout !== 1'b0 || ovf !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: RVALID=%0b RESULT=%b RID=%0b COUT=%0b OVF=%0b GNT=%0b%0b, required all 0",
                  rvalid, result, rid, cout, ovf, gnt0, gnt1);
      end else $display("[TB] reset state ok");

      // Add with signed overflow. The grant is due in the first cycle after release.
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(1'b0, 4'b1000, 1'b0, 1'b1);
      wait_gnt(0, 1, 1'b1, c);
      @(negedge clk);
      req0 = 1'b0; a0 = 4'hF; b0 = 4'hF; op0 = 1'b1;  // must not disturb in-flight op
      drain(10);

      // Subtract without overflow, requester 1
      @(negedge clk);
      req1 = 1'b1; a1 = 4'b0011; b1 = 4'b0101; op1 = 1'b1;
      push_exp(1'b1, 4'b1110, 1'b0, 1'b0);
      wait_gnt(1, 4, 1'b1, c);
      @(negedge clk);
      req1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
      drain(10);

      // Subtract with overflow, requester 0
      @(negedge clk);
      req0 = 1'b1; a0 = 4'b1000; b0 = 4'b0001; op0 = 1'b1;
      push_exp(1'b0, 4'b0111, 1'b1, 1'b1);
      wait_gnt(0, 4, 1'b1, c);
      @(negedge clk);
      req0 = 1'b0;
      drain(10);

      // Backpressure: 1001+1001 held in DONE while REQ1 stays high
      @(negedge clk);
      rready = 1'b0;
      req1 = 1'b1; a1 = 4'b1001; b1 = 4'b1001; op1 = 1'b0;
      push_exp(1'b1, 4'b0010, 1'b1, 1'b1);
      wait_gnt(1, 4, 1'b1, c);
      @(negedge clk);
      a1 = 4'b0101; b1 = 4'b0010; op1 = 1'b1;  // next pending op from requester 1
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         #1;
         if (rvalid) seen = 1'b1;
         else @(negedge clk);
      end
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL bp_rvalid: RVALID=0, required 1");
      end
      hold_res = result;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         n_tests++;
         if (rvalid !== 1'b1 || result !== hold_res || gnt0 || gnt1) begin
            n_fail++;
            $display("FAIL bp_hold: RVALID=%0b RESULT=%b GNT=%0b%0b, required RVALID=1 RESULT=%b no grant",
                     rvalid, result, gnt0, gnt1, hold_res);
         end else $display("[TB] backpressure hold cycle %0d ok", i);
      end
      @(negedge clk);
      rready = 1'b1;
      push_exp(1'b1, 4'b0011, 1'b1, 1'b0);
      @(negedge clk);
      wait_gnt(1, 1, 1'b1, c);
      @(negedge clk);
      req1 = 1'b0;
      drain(10);

      // Reset in EXEC discards the transaction
      @(negedge clk);
      req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0100; op0 = 1'b0;
      wait_gnt(0, 4, 1'b0, c);
      @(negedge clk);
      rst_n = 1'b0;
      req1 = 1'b1; a1 = 4'b0100; b1 = 4'b0110; op1 = 1'b1;
      a0 = 4'b0010; b0 = 4'b0011; op0 = 1'b0;
      #1;
      n_tests++;
      if (rvalid !== 1'b0 || result !== 4'd0 || rid !== 1'b0 || cout !== 1'b0 || ovf !== 1'b0 || gnt0 || gnt1) begin
         n_fail++;
         $display("FAIL async_reset: RVALID=%0b RESULT=%b RID=%0b COUT=%0b OVF=%0b GNT=%0b%0b, required all 0",
                  rvalid, result, rid, cout, ovf, gnt0, gnt1);
      end else $display("[TB] async reset in EXEC ok");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_tests++;
         if (rvalid !== 1'b0 || gnt0 || gnt1) begin
            n_fail++;
            $display("FAIL reset_hold: RVALID=%0b GNT=%0b%0b, required 0", rvalid, gnt0, gnt1);
         end
      end

      // Tie with both held: 0,1,0,1 spaced 3 cycles apart
      push_exp(1'b0, 4'b0101, 1'b0, 1'b0);
      push_exp(1'b1, 4'b1110, 1'b0, 1'b0);
      push_exp(1'b0, 4'b0101, 1'b0, 1'b0);
      push_exp(1'b1, 4'b1110, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_gnt(0, 1, 1'b1, prev_c);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         wait_gnt(k % 2, 6, 1'b1, c);
         n_tests++;
         if (c - prev_c != 3) begin
            n_fail++;
            $display("FAIL grant_spacing: %0d cycles, required 3", c - prev_c);
         end
         prev_c = c;
      end
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      drain(10);

      repeat (3) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0 || gnt_cyc_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: %0d results %0d grants pending, required 0", exp_q.size(), gnt_cyc_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
